// File: rtl/lc3_arb_pkg.sv
// Shared types and constants for the LC3 fetch/data memory arbiter.
package lc3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INST_WAIT,
        DATA_WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        GNT_INST,
        GNT_DATA
    } arb_grant_e;

    localparam logic [15:0] BAD_DATA = 16'hDEAD;

endpackage

// File: rtl/lc3_arb_watchdog.sv
// Memory-ack watchdog for lc3_mem_arbiter; only built with LC3_ARB_TIMEOUT_EN.
module lc3_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th waiting cycle that saw no ack.
    assign expire = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one single-ported 64Kx16 memory between the LC3 fetch and data ports.
// Define LC3_ARB_TIMEOUT_EN to add the ack watchdog and the sticky arb_err flag.
module lc3_mem_arbiter
    import lc3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_err
);

    localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    if (STARVE_MAX < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("lc3_mem_arbiter: STARVE_MAX must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_e    state;
    arb_grant_e    grant;
    logic [SW-1:0] starve_cnt;
    logic          any_req;
    logic          issue;
    logic          waiting;
    logic          expire;

    assign any_req = instrmem_rd | data_req;
    assign issue   = (state == IDLE) && any_req;
    assign waiting = (state == INST_WAIT) || (state == DATA_WAIT);

    // Data has priority; a fetch that has watched STARVE_MAX data grants goes next.
    always_comb begin
        grant = GNT_DATA;
        if (instrmem_rd && (!data_req || starve_cnt == STARVE_LIM)) begin
            grant = GNT_INST;
        end
    end

`ifdef LC3_ARB_TIMEOUT_EN
    lc3_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (issue),
        .run   (waiting && !mem_ack),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_err <= 1'b0;
        end else if (expire) begin
            arb_err <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign arb_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            Instr_dout     <= '0;
            Data_dout      <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
        end else begin
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_req <= 1'b1;
                        if (grant == GNT_INST) begin
                            mem_we     <= 1'b0;
                            mem_addr   <= pc;
                            starve_cnt <= '0;
                            state      <= INST_WAIT;
                        end else begin
                            mem_we    <= ~Data_rd;
                            mem_addr  <= Data_addr;
                            mem_wdata <= Data_din;
                            state     <= DATA_WAIT;
                            if (instrmem_rd && starve_cnt != STARVE_LIM) begin
                                starve_cnt <= starve_cnt + SW'(1);
                            end
                        end
                    end
                end
                INST_WAIT: begin
                    if (mem_ack || expire) begin
                        mem_req        <= 1'b0;
                        Instr_dout     <= mem_ack ? mem_rdata : DATA_W'(BAD_DATA);
                        complete_instr <= 1'b1;
                        state          <= RESP;
                    end
                end
                DATA_WAIT: begin
                    if (mem_ack || expire) begin
                        mem_req       <= 1'b0;
                        complete_data <= 1'b1;
                        state         <= RESP;
                        if (!mem_ack) begin
                            Data_dout <= DATA_W'(BAD_DATA);
                        end else if (!mem_we) begin
                            Data_dout <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: random fetch/data traffic against a memory BFM.
module tb_lc3_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        data_req;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        arb_err;

    lc3_mem_arbiter #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .STARVE_MAX    (SMAX),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instrmem_rd   (instrmem_rd),
        .pc            (pc),
        .Instr_dout    (Instr_dout),
        .complete_instr(complete_instr),
        .data_req      (data_req),
        .Data_rd       (Data_rd),
        .Data_addr     (Data_addr),
        .Data_din      (Data_din),
        .Data_dout     (Data_dout),
        .complete_data (complete_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .arb_err       (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          rd;
        logic [15:0] a;
        logic [15:0] d;
    } txn_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    logic [15:0] bmem [0:65535];
    logic [15:0] rmem [0:65535];

    txn_t        fq[$];
    txn_t        dq[$];
    txn_t        cur;
    bit          inflight = 1'b0;
    int          starve = 0;
    logic [15:0] exp_i = '0;
    logic [15:0] exp_d = '0;
    bit          prev_req = 1'b0;
    bit          tmo_mode = 1'b0;
    bit          glog[$];

    int          bfm_fixed = 0;
    bit          bfm_never = 1'b0;
    bit          bfm_busy = 1'b0;
    int          bfm_left = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial forever @(posedge clk) cyc++;

    // Memory BFM: ack after a fixed or random wait, writes applied on the ack.
    initial forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (!reset || !mem_req) begin
            bfm_busy = 1'b0;
        end else begin
            if (!bfm_busy) begin
                bfm_busy = 1'b1;
                bfm_left = (bfm_fixed >= 0) ? bfm_fixed : int'($urandom_range(0, 3));
            end
            if (!bfm_never) begin
                if (bfm_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr];
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    bfm_busy = 1'b0;
                end else begin
                    bfm_left--;
                end
            end
        end
    end

    // Reference model + monitor: predicts each grant from pending requests and checks the outputs.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            inflight = 1'b0;
            starve   = 0;
            exp_i    = '0;
            exp_d    = '0;
            prev_req = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                chk("issue_while_busy", 32'(inflight), 32'd0);
                chk("issue_has_requester", 32'((fq.size() + dq.size()) != 0), 32'd1);
                if (fq.size() != 0 && (dq.size() == 0 || starve == SMAX)) begin
                    cur    = fq.pop_front();
                    starve = 0;
                    inflight = 1'b1;
                end else if (dq.size() != 0) begin
                    if (fq.size() != 0 && starve < SMAX) starve++;
                    cur = dq.pop_front();
                    inflight = 1'b1;
                end
            end
            if (mem_req && inflight) begin
                chk("mem_addr", 32'(mem_addr), 32'(cur.a));
                chk("mem_we", 32'(mem_we), 32'(cur.is_data && !cur.rd));
                if (cur.is_data && !cur.rd) chk("mem_wdata", 32'(mem_wdata), 32'(cur.d));
            end
            chk("single_pulse", 32'(complete_instr & complete_data), 32'd0);
            if (complete_instr) begin
                chk("instr_done_expected", 32'(inflight && !cur.is_data), 32'd1);
                exp_i = tmo_mode ? 16'hDEAD : rmem[cur.a];
                chk("Instr_dout", 32'(Instr_dout), 32'(exp_i));
                inflight = 1'b0;
                glog.push_back(1'b0);
            end
            if (complete_data) begin
                chk("data_done_expected", 32'(inflight && cur.is_data), 32'd1);
                if (tmo_mode) exp_d = 16'hDEAD;
                else if (cur.rd) exp_d = rmem[cur.a];
                else rmem[cur.a] = cur.d;
                chk("Data_dout", 32'(Data_dout), 32'(exp_d));
                inflight = 1'b0;
                glog.push_back(1'b1);
            end
            prev_req = mem_req;
        end
    end

    task automatic fetch_txn(input logic [15:0] a, input bit drop, output int lat);
        int unsigned t0;
        bit          done;
        txn_t        t;
        #1;
        t.is_data = 1'b0; t.rd = 1'b1; t.a = a; t.d = '0;
        instrmem_rd = 1'b1;
        pc = a;
        fq.push_back(t);
        t0 = cyc;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = complete_instr;
        end
        lat = int'(cyc - t0);
        chk("fetch_completes", 32'(done), 32'd1);
        if (drop) begin
            #1;
            instrmem_rd = 1'b0;
        end
    endtask

    task automatic data_txn(input bit rd, input logic [15:0] a, input logic [15:0] d,
                            input bit drop, output int lat);
        int unsigned t0;
        bit          done;
        txn_t        t;
        #1;
        t.is_data = 1'b1; t.rd = rd; t.a = a; t.d = d;
        data_req = 1'b1;
        Data_rd = rd;
        Data_addr = a;
        Data_din = d;
        dq.push_back(t);
        t0 = cyc;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = complete_data;
        end
        lat = int'(cyc - t0);
        chk("data_completes", 32'(done), 32'd1);
        if (drop) begin
            #1;
            data_req = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        bit exp_seq [10];
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        reset = 1'b0;
        instrmem_rd = 1'b0; pc = '0;
        data_req = 1'b0; Data_rd = 1'b0; Data_addr = '0; Data_din = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            bmem[i] = 16'($urandom);
            rmem[i] = bmem[i];
        end
        bmem[16'h3000] = 16'h1234;
        rmem[16'h3000] = 16'h1234;

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_Instr_dout", 32'(Instr_dout), 32'd0);
        chk("rst_Data_dout", 32'(Data_dout), 32'd0);
        chk("rst_complete", 32'({complete_instr, complete_data}), 32'd0);
        chk("rst_arb_err", 32'(arb_err), 32'd0);
        #2 reset = 1'b1;

        // 0-wait fetch
        @(negedge clk);
        fetch_txn(16'h3000, 1'b1, lat);
        chk("fetch_latency_0wait", 32'(lat), 32'd2);
        chk("fetch_value", 32'(Instr_dout), 32'h1234);

        // write leaves Data_dout alone, then read it back on both ports
        @(negedge clk);
        data_txn(1'b0, 16'h4000, 16'hBEEF, 1'b1, lat);
        chk("write_latency", 32'(lat), 32'd2);
        chk("write_keeps_dout", 32'(Data_dout), 32'h0000);
        @(negedge clk);
        data_txn(1'b1, 16'h4000, 16'h0000, 1'b1, lat);
        chk("readback_value", 32'(Data_dout), 32'hBEEF);

        // slow memory
        bfm_fixed = 5;
        @(negedge clk);
        fetch_txn(16'h4000, 1'b1, lat);
        chk("fetch_latency_wait5", 32'(lat), 32'd7);
        chk("fetch_slow_value", 32'(Instr_dout), 32'hBEEF);
        bfm_fixed = 0;

        // both ports held continuously: starvation guard
        @(negedge clk);
        glog.delete();
        fork
            begin
                int ld;
                for (int k = 0; k < 8; k++)
                    data_txn(k[0], 16'h4010 + 16'(k), 16'hA000 + 16'(k), k == 7, ld);
            end
            begin
                int lf;
                for (int k = 0; k < 2; k++)
                    fetch_txn(16'h3100 + 16'(k), k == 1, lf);
            end
        join
        chk("starve_grant_count", 32'(glog.size()), 32'd10);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            chk($sformatf("starve_grant_%0d", k), 32'(glog[k]), 32'(exp_seq[k]));

        // reset while a write waits for its ack
        @(negedge clk);
        bfm_never = 1'b1;
        #1;
        begin
            txn_t t;
            t.is_data = 1'b1; t.rd = 1'b0; t.a = 16'h4100; t.d = 16'h5555;
            data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4100; Data_din = 16'h5555;
            dq.push_back(t);
        end
        repeat (3) @(negedge clk);
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_req_async", 32'(mem_req), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid_Data_dout", 32'(Data_dout), 32'd0);
        data_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_complete", 32'(complete_data), 32'd0);
        end
        #2 reset = 1'b1;
        bfm_never = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_idle", 32'(mem_req), 32'd0);
        fetch_txn(16'h3000, 1'b1, lat);
        chk("after_rst_latency", 32'(lat), 32'd2);

        // random traffic on both ports with random memory latency
        bfm_fixed = -1;
        @(negedge clk);
        fork
            begin
                int l;
                int g;
                for (int k = 0; k < 40; k++) begin
                    g = int'($urandom_range(0, 2));
                    data_txn(1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 15)),
                             16'($urandom), (g != 0) || (k == 39), l);
                    repeat (g) @(negedge clk);
                end
            end
            begin
                int l;
                int g;
                logic [15:0] a;
                for (int k = 0; k < 40; k++) begin
                    g = int'($urandom_range(0, 2));
                    a = ($urandom_range(0, 1) != 0) ? 16'h4000 + 16'($urandom_range(0, 15))
                                                     : 16'($urandom);
                    fetch_txn(a, (g != 0) || (k == 39), l);
                    repeat (g) @(negedge clk);
                end
            end
        join
        bfm_fixed = 0;

`ifdef LC3_ARB_TIMEOUT_EN
        @(negedge clk);
        bfm_never = 1'b1;
        tmo_mode = 1'b1;
        fetch_txn(16'h3000, 1'b1, lat);
        chk("timeout_latency", 32'(lat), 32'd9);
        chk("timeout_dout", 32'(Instr_dout), 32'hDEAD);
        chk("timeout_arb_err", 32'(arb_err), 32'd1);
        bfm_never = 1'b0;
        tmo_mode = 1'b0;
        @(negedge clk);
        fetch_txn(16'h3000, 1'b1, lat);
        chk("post_timeout_value", 32'(Instr_dout), 32'h1234);
        chk("arb_err_sticky", 32'(arb_err), 32'd1);
`else
        chk("arb_err_tied_low", 32'(arb_err), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one single-ported unified 64K x 16 memory between the LC3 core's instruction-fetch port and data-access port.
- Sits between the core's fetch/memory stages and the memory model or BFM; replaces the two separate memory handshakes.
- Serialises requests, arbitrates collisions (data-priority with a fetch starvation guard), and tolerates variable memory latency.
- Returns completion pulses in the form the core already consumes: complete_instr and complete_data.

Parameters:
- ADDR_W, 16, address width on both sides.
- DATA_W, 16, data width.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; after that, fetch wins.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only when the optional feature is enabled).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instrmem_rd  in  1  fetch request, held high until complete_instr.
- pc  in  ADDR_W  fetch address, stable while instrmem_rd is high.
- Instr_dout  out  DATA_W  fetched instruction, registered.
- complete_instr  out  1  one-cycle fetch-done pulse.
- data_req  in  1  data access request, held high until complete_data.
- Data_rd  in  1  1 = read, 0 = write; stable while data_req is high.
- Data_addr  in  ADDR_W  data address.
- Data_din  in  DATA_W  write data.
- Data_dout  out  DATA_W  read data, registered.
- complete_data  out  1  one-cycle data-done pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.
- arb_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0), asynchronous and immediate:
  - state=IDLE, starve_cnt=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Instr_dout=0, Data_dout=0, complete_instr=0, complete_data=0, arb_err=0.
- Reset mid-transaction drops mem_req at once; the outstanding access is abandoned with no completion pulse. The memory side must discard an ack with no request.
- States: IDLE, INST_WAIT, DATA_WAIT, RESP.
- IDLE, request(s) seen at edge N:
  - Selects a winner and registers mem_req=1, mem_addr, mem_we, mem_wdata at edge N.
  - Moves to INST_WAIT or DATA_WAIT.
  - Outputs are visible from cycle N+1.
- Fetch issue: mem_we=0, mem_addr=pc.
- Data issue: mem_we=~Data_rd, mem_addr=Data_addr, mem_wdata=Data_din.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - starve_cnt increments on each data grant made while instrmem_rd=1, saturates at STARVE_MAX, and clears on every fetch grant.
- *_WAIT:
  - mem_req and the memory outputs are held stable.
  - On the edge where mem_ack=1: mem_req=0; read data is captured into Instr_dout or Data_dout (writes leave Data_dout unchanged); go to RESP.
  - mem_ack may arrive the first cycle mem_req is seen high, giving a 0-wait memory.
- RESP:
  - The matching complete_* is high for exactly this one cycle.
  - Next edge goes to IDLE. RESP ignores new requests, so the requester has one cycle to drop its request.
- Minimum latency, request to complete pulse: 2 cycles + memory wait.
- Back-to-back accesses: one access per (3 + wait) cycles.
- Never more than one access outstanding. complete_instr and complete_data are never high together.
- A request dropped before completion (protocol violation) does not cancel the issued access; its completion pulse still fires.
- Addresses are used as-is; no wrap or offset translation (the 16'h3000 base is handled by the loader).

Optional Feature:
- Macro: LC3_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in *_WAIT. When it reaches TIMEOUT_CYCLES without mem_ack: mem_req=0, go to RESP, the target dout gets 16'hDEAD, complete_* pulses, arb_err is set (sticky until reset).
  - The counter clears on every issue.
- Not defined: no counter is built, arb_err is tied to 0, and a missing ack stalls forever.

Decomposition:
- Package lc3_arb_pkg:
  - arb_state_e {IDLE, INST_WAIT, DATA_WAIT, RESP}.
  - arb_grant_e {GNT_INST, GNT_DATA}.
  - localparam BAD_DATA = 16'hDEAD.
- Sub-module lc3_arb_watchdog: counter, clear, expire output; instantiated only under LC3_ARB_TIMEOUT_EN.

Test Plan:
- Reset, then instrmem_rd=1, pc=16'h3000, memory returns 16'h1234 with 0 wait -> mem_req from cycle 1; complete_instr pulses at cycle 2; Instr_dout=16'h1234.
- data_req=1, Data_rd=0, Data_addr=16'h4000, Data_din=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF; complete_data pulses once; Data_dout unchanged.
- Both requests held continuously, STARVE_MAX=4 -> grant sequence is D,D,D,D,I,D,D,D,D,I; never two pulses in the same cycle.
- Fetch with mem_ack delayed 5 cycles -> mem_req and mem_addr held stable 5 cycles; complete_instr pulses exactly 1 cycle after the ack.
- Reset asserted in DATA_WAIT -> mem_req=0 asynchronously (same cycle); no complete_data pulse; state IDLE.
- LC3_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ack never sent -> after 8 cycles complete_instr pulses, Instr_dout=16'hDEAD, arb_err=1 and stays 1.
